// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the fetch PC, issues word requests on a req/gnt/rvalid bus,
// buffers returned words in a small prefetch FIFO and drops stale responses after a redirect.
module fetch_unit #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_pc_valid,
  input  logic [31:0] set_pc,
  input  logic        flush,
  input  logic        stall_if,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_gnt,
  input  logic        instr_rvalid,
  input  logic [31:0] instr_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OUT_W = 8;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic             stale_q, stale_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] disc_q, disc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [31:0]      fifo_pc_q   [FIFO_DEPTH];

  logic             gnt_ok;
  logic             clear;
  logic             drop;
  logic             push;
  logic             pop;
  logic             fifo_we;
  logic [OUT_W-1:0] live;

  // Next-state: bus bookkeeping, FIFO pointers, redirect handling, request issue
  always_comb begin
    gnt_ok  = req_q & instr_gnt;
    clear   = set_pc_valid | flush;
    drop    = instr_rvalid & (disc_q != '0);
    push    = instr_rvalid & ~drop;
    pop     = (cnt_q != '0) & ~stall_if & ~flush;
    fifo_we = push & ~clear;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    stale_d    = stale_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;

    out_d  = out_q + OUT_W'(gnt_ok) - OUT_W'(instr_rvalid);
    // A grant for a request issued before a redirect is born already discarded
    disc_d = disc_q - OUT_W'(drop) + OUT_W'(gnt_ok & stale_q);
    cnt_d  = cnt_q + CNT_W'(fifo_we) - CNT_W'(pop);

    if (gnt_ok && !stale_q) fetch_pc_d = fetch_pc_q + 32'd4;
    if (push)               resp_pc_d  = resp_pc_q + 32'd4;
    if (fifo_we)            wptr_d     = wptr_q + PTR_W'(1);
    if (pop)                rptr_d     = rptr_q + PTR_W'(1);

    if (gnt_ok) stale_d = 1'b0;
    if (req_q && !instr_gnt && clear) stale_d = 1'b1;

    if (clear) begin
      cnt_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
      disc_d = out_d;
      if (set_pc_valid) fetch_pc_d = set_pc;
      resp_pc_d = fetch_pc_d;
    end

    // Issue only when every live request is guaranteed a FIFO slot
    live = OUT_W'(cnt_d) + out_d - disc_d;
    if (req_q && !instr_gnt) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d = (live < OUT_W'(FIFO_DEPTH));
      if (req_d) addr_d = fetch_pc_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= BOOT_ADDR;
      resp_pc_q  <= BOOT_ADDR;
      req_q      <= 1'b0;
      addr_q     <= BOOT_ADDR;
      stale_q    <= 1'b0;
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      stale_q    <= stale_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      if (fifo_we) begin
        fifo_data_q[wptr_q] <= instr_rdata;
        fifo_pc_q[wptr_q]   <= resp_pc_q;
      end
    end
  end

  assign instr_req  = req_q;
  assign instr_addr = addr_q;
  assign if_valid   = (cnt_q != '0);
  assign if_instr   = fifo_data_q[rptr_q];
  assign if_pc      = fifo_pc_q[rptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bus responder plus a transaction-level model of the PC stream seen by ID.
module tb_fetch_unit;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        set_pc_valid;
  logic [31:0] set_pc;
  logic        flush;
  logic        stall_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  fetch_unit #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .set_pc_valid(set_pc_valid), .set_pc(set_pc), .flush(flush), .stall_if(stall_if),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int ready; } rsp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  rsp_t        bq[$];
  int          last_ready;
  logic [31:0] exp_pc;
  logic [31:0] model_fetch;
  bit          stale_pend;
  bit          prev_held;
  logic [31:0] prev_addr;
  int          gnt_mode, stall_mode, dly_min, dly_max;
  bit          rand_redir, do_redir, do_flush;
  logic [31:0] redir_pc;
  int          pops = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    last_ready   = 0;
    exp_pc       = BOOT;
    model_fetch  = BOOT;
    stale_pend   = 0;
    prev_held    = 0;
    do_redir     = 0;
    do_flush     = 0;
    set_pc_valid = 0;
    set_pc       = 0;
    flush        = 0;
    stall_if     = 0;
    instr_gnt    = 0;
    instr_rvalid = 0;
    instr_rdata  = 0;
  endtask

  // One bus cycle at the negedge: check observed outputs, update the model, drive next inputs
  task automatic step();
    logic        req, vld;
    logic [31:0] addr, ipc, iins, tgt;
    bit          g, rv, st, rd, fl;
    rsp_t        r, nr;
    int          d, x;
    req = instr_req; addr = instr_addr; vld = if_valid; ipc = if_pc; iins = if_instr;
    if (prev_held) begin
      chk("hold_req", 32'(req), 32'd1);
      chk("hold_addr", addr, prev_addr);
    end
    case (gnt_mode)
      0:       g = 1'b1;
      1:       g = ($urandom_range(0, 9) < 7);
      default: g = 1'b0;
    endcase
    rv = 1'b0;
    r.addr = 0; r.ready = 0;
    if (bq.size() > 0 && bq[0].ready <= cyc) begin
      r  = bq.pop_front();
      rv = 1'b1;
    end
    st = (stall_mode == 1) || (stall_mode == 2 && $urandom_range(0, 9) < 3);
    rd = do_redir; fl = do_flush; tgt = redir_pc;
    do_redir = 0; do_flush = 0;
    if (rand_redir && !rd && !fl) begin
      x = $urandom_range(0, 99);
      if (x < 5) begin
        rd  = 1'b1;
        tgt = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h000F_FFFC);
      end else if (x < 8) begin
        fl = 1'b1;
      end
    end
    if (vld && !st && !(rd || fl)) begin
      chk("if_pc", ipc, exp_pc);
      chk("if_instr", iins, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (req && g) begin
      if (stale_pend) stale_pend = 0;
      else begin
        chk("req_addr", addr, model_fetch);
        model_fetch = model_fetch + 32'd4;
      end
      d        = $urandom_range(dly_min, dly_max);
      nr.addr  = addr;
      nr.ready = (cyc + d > last_ready) ? cyc + d : last_ready;
      last_ready = nr.ready;
      bq.push_back(nr);
    end
    prev_held = req && !g;
    prev_addr = addr;
    if ((rd || fl) && req && !g) stale_pend = 1;
    if (rd) begin
      model_fetch = tgt;
      exp_pc      = tgt;
    end else if (fl) begin
      exp_pc = model_fetch;
    end
    instr_gnt    = g;
    instr_rvalid = rv;
    instr_rdata  = rv ? mem_word(r.addr) : $urandom();
    stall_if     = st;
    set_pc_valid = rd;
    flush        = rd || fl;
    set_pc       = rd ? tgt : ($urandom() & 32'hFFFF_FFFC);
  endtask

  task automatic tick();
    step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic boot_checks();
    chk("rst_req", 32'(instr_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    tick();
    chk("boot_req", 32'(instr_req), 32'd1);
    chk("boot_addr", instr_addr, BOOT);
    tick();
    tick();
    chk("boot_valid", 32'(if_valid), 32'd1);
    chk("boot_pc", if_pc, BOOT);
  endtask

  // Zero-wait redirect: request at N+1, instruction visible at N+3
  task automatic redirect_latency(input string tag, input logic [31:0] tgt);
    do_redir = 1; redir_pc = tgt;
    tick();
    chk({tag, "_req"}, 32'(instr_req), 32'd1);
    chk({tag, "_addr"}, instr_addr, tgt);
    tick();
    tick();
    chk({tag, "_valid"}, 32'(if_valid), 32'd1);
    chk({tag, "_pc"}, if_pc, tgt);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int          k;
    int          pops0;
    logic [31:0] held_addr;
    gnt_mode = 0; stall_mode = 0; dly_min = 1; dly_max = 1; rand_redir = 0;
    model_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_req_async", 32'(instr_req), 32'd0);
    chk("rst_addr", instr_addr, BOOT);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    boot_checks();
    repeat (8) tick();

    // Stall fills the FIFO and stops requests
    stall_mode = 1;
    repeat (10) tick();
    chk("stall_req", 32'(instr_req), 32'd0);
    chk("stall_valid", 32'(if_valid), 32'd1);
    stall_mode = 0;
    tick();
    chk("stall_rel_valid", 32'(if_valid), 32'd1);
    repeat (5) tick();

    redirect_latency("redir100", 32'h0000_0100);
    repeat (4) tick();

    // Two late responses in flight when redirecting
    dly_min = 3; dly_max = 3;
    k = 0;
    while (bq.size() < 2 && k < 20) begin tick(); k++; end
    chk("wait_two_outstanding", 32'(bq.size() >= 2), 32'd1);
    do_redir = 1; redir_pc = 32'h0000_0180;
    tick();
    repeat (12) tick();
    dly_min = 1; dly_max = 1;
    repeat (4) tick();

    // Redirect while a request is held without grant
    gnt_mode = 2;
    k = 0;
    while (!instr_req && k < 20) begin tick(); k++; end
    chk("wait_req", 32'(instr_req), 32'd1);
    held_addr = instr_addr;
    do_redir = 1; redir_pc = 32'h0000_0200;
    tick();
    repeat (3) tick();
    chk("held_req", 32'(instr_req), 32'd1);
    chk("held_addr", instr_addr, held_addr);
    gnt_mode = 0;
    tick();
    chk("post_stale_req", 32'(instr_req), 32'd1);
    chk("post_stale_addr", instr_addr, 32'h0000_0200);
    repeat (8) tick();

    // Redirect in a cycle carrying both a grant and a response
    k = 0;
    while (!(instr_req && bq.size() > 0 && bq[0].ready <= cyc) && k < 20) begin tick(); k++; end
    chk("wait_gnt_rvalid", 32'(instr_req && bq.size() > 0), 32'd1);
    redirect_latency("redir300", 32'h0000_0300);
    repeat (6) tick();

    // Randomized traffic: grant gaps, variable latency, stalls, redirects, flushes, wrap
    gnt_mode = 1; stall_mode = 2; dly_min = 1; dly_max = 4; rand_redir = 1;
    repeat (1500) tick();

    // Drain and confirm forward progress
    gnt_mode = 0; stall_mode = 0; dly_min = 1; dly_max = 1; rand_redir = 0;
    pops0 = pops;
    repeat (40) tick();
    chk("progress", 32'(pops - pops0 >= 10), 32'd1);

    // Reset with a full FIFO and responses in flight
    stall_mode = 1; dly_min = 3; dly_max = 3;
    repeat (6) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_req", 32'(instr_req), 32'd0);
    model_reset();
    gnt_mode = 0; stall_mode = 0; dly_min = 1; dly_max = 1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    boot_checks();
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
